// File: rtl/hazard_stall_controller_pkg.sv
// Shared encodings and constants for the pipeline hazard sequencer.
package hazard_stall_controller_pkg;

    typedef enum logic [1:0] {
        HZ_RUN    = 2'b00,
        HZ_LSTALL = 2'b01,
        HZ_MWAIT  = 2'b10
    } hz_state_e;

    localparam logic [4:0] REG_ZERO = 5'b0;
    localparam int         HZ_CNT_W = 16;

endpackage

// File: rtl/hazard_stall_controller_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module hz_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/hazard_stall_controller.sv
// Load-use stall, branch squash and memory-wait freeze sequencer for the 5-stage core.
module hazard_stall_controller
    import hazard_stall_controller_pkg::*;
#(
    parameter int LOAD_BUBBLES = 1,
    parameter int CNT_W        = HZ_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       IFIDregr1,
    input  logic [4:0]       IFIDregr2,
    input  logic             IFIDuse1,
    input  logic             IFIDuse2,
    input  logic [4:0]       IDEXregrd,
    input  logic             IDEXmemread,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IFIDflush,
    output logic             IDEXbubble,
    output logic             PipeFreeze,
    output logic [1:0]       hz_state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [1:0] BCNT_INIT = 2'(LOAD_BUBBLES - 1);

    logic [1:0] state_q, state_d;
    logic [1:0] ret_q, ret_d;
    logic [1:0] bcnt_q, bcnt_d;
    logic [1:0] eval_st;
    logic       hit, mem_wait;

    assign hit = IDEXmemread && (IDEXregrd != REG_ZERO) &&
                 ((IFIDuse1 && (IDEXregrd == IFIDregr1)) ||
                  (IFIDuse2 && (IDEXregrd == IFIDregr2)));
    assign mem_wait = dmem_req && !dmem_ready;

    // On the ready cycle of a wait, the saved state is evaluated as if live.
    assign eval_st = ((state_q == HZ_MWAIT) && dmem_ready) ? ret_q : state_q;

    always_comb begin
        PCWrite    = 1'b1;
        IFIDWrite  = 1'b1;
        IFIDflush  = 1'b0;
        IDEXbubble = 1'b0;
        PipeFreeze = 1'b0;
        state_d    = state_q;
        ret_d      = ret_q;
        bcnt_d     = bcnt_q;
        case (eval_st)
            HZ_RUN: begin
                state_d = HZ_RUN;
                if (mem_wait) begin
                    PCWrite    = 1'b0;
                    IFIDWrite  = 1'b0;
                    PipeFreeze = 1'b1;
                    ret_d      = HZ_RUN;
                    state_d    = HZ_MWAIT;
                end else if (branch_taken) begin
                    IFIDflush  = 1'b1;
                    IDEXbubble = 1'b1;
                end else if (hit) begin
                    PCWrite    = 1'b0;
                    IFIDWrite  = 1'b0;
                    IDEXbubble = 1'b1;
                    if (LOAD_BUBBLES > 1) begin
                        state_d = HZ_LSTALL;
                        bcnt_d  = BCNT_INIT;
                    end
                end
            end
            HZ_LSTALL: begin
                if (mem_wait) begin
                    PCWrite    = 1'b0;
                    IFIDWrite  = 1'b0;
                    PipeFreeze = 1'b1;
                    ret_d      = HZ_LSTALL;
                    state_d    = HZ_MWAIT;
                end else begin
                    PCWrite    = 1'b0;
                    IFIDWrite  = 1'b0;
                    IDEXbubble = 1'b1;
                    bcnt_d     = bcnt_q - 2'd1;
                    state_d    = (bcnt_q == 2'd1) ? HZ_RUN : HZ_LSTALL;
                end
            end
            HZ_MWAIT: begin
                PCWrite    = 1'b0;
                IFIDWrite  = 1'b0;
                PipeFreeze = 1'b1;
                state_d    = HZ_MWAIT;
            end
            default: begin
                state_d = HZ_RUN;
                ret_d   = HZ_RUN;
                bcnt_d  = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HZ_RUN;
            ret_q   <= HZ_RUN;
            bcnt_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            bcnt_q  <= bcnt_d;
        end
    end

    assign hz_state = state_q;

    hz_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (!PCWrite),
        .cnt   (stall_cnt)
    );

    hz_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (IFIDflush),
        .cnt   (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench: four controller instances (LOAD_BUBBLES 1..3, and a 3-bit counter copy).
module tb_hazard_stall_controller;

    typedef struct packed {
        logic        pc, ifw, fl, bub, frz;
        logic [1:0]  st;
        logic [15:0] sc, fc;
    } resp_t;

    typedef struct {
        string name;
        int    dut;
        resp_t r;
    } item_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] r1, r2, rd;
    logic u1, u2, mr, br, req, rdy;

    logic [2:0]       pcw, ifw, fl, bub, frz;
    logic [2:0][1:0]  st;
    logic [2:0][15:0] sc, fc;
    logic       pcw3, ifw3, fl3, bub3, frz3;
    logic [1:0] st3;
    logic [2:0] sc3, fc3;

    item_t q[$];
    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        hazard_stall_controller #(.LOAD_BUBBLES(g + 1), .CNT_W(16)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .IFIDregr1(r1), .IFIDregr2(r2), .IFIDuse1(u1), .IFIDuse2(u2),
            .IDEXregrd(rd), .IDEXmemread(mr), .branch_taken(br),
            .dmem_req(req), .dmem_ready(rdy),
            .PCWrite(pcw[g]), .IFIDWrite(ifw[g]), .IFIDflush(fl[g]),
            .IDEXbubble(bub[g]), .PipeFreeze(frz[g]), .hz_state(st[g]),
            .stall_cnt(sc[g]), .flush_cnt(fc[g])
        );
    end

    hazard_stall_controller #(.LOAD_BUBBLES(1), .CNT_W(3)) u_dut_sat (
        .clk(clk), .rst_n(rst_n),
        .IFIDregr1(r1), .IFIDregr2(r2), .IFIDuse1(u1), .IFIDuse2(u2),
        .IDEXregrd(rd), .IDEXmemread(mr), .branch_taken(br),
        .dmem_req(req), .dmem_ready(rdy),
        .PCWrite(pcw3), .IFIDWrite(ifw3), .IFIDflush(fl3),
        .IDEXbubble(bub3), .PipeFreeze(frz3), .hz_state(st3),
        .stall_cnt(sc3), .flush_cnt(fc3)
    );

    function automatic resp_t mk(logic p, logic i, logic f, logic b, logic z,
                                 logic [1:0] s, int c_st, int c_fl);
        resp_t r;
        r.pc = p; r.ifw = i; r.fl = f; r.bub = b; r.frz = z;
        r.st = s; r.sc = 16'(c_st); r.fc = 16'(c_fl);
        return r;
    endfunction

    function automatic resp_t actual(int d);
        resp_t r;
        if (d == 3) begin
            r = {pcw3, ifw3, fl3, bub3, frz3, st3, 13'd0, sc3, 13'd0, fc3};
        end else begin
            r = {pcw[d], ifw[d], fl[d], bub[d], frz[d], st[d], sc[d], fc[d]};
        end
        return r;
    endfunction

    // Monitor: pop one expectation per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            item_t it;
            resp_t a;
            it = q.pop_front();
            a  = actual(it.dut);
            n_checks++;
            if (a === it.r) n_pass++;
            else $display("FAIL %s dut%0d: got %h expected %h", it.name, it.dut, a, it.r);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int g = 0; g < 3; g++)
                assert (!(st[g] == 2'b01 && br));
        end
    end

    task automatic idle();
        r1 = 0; r2 = 0; rd = 0; u1 = 0; u2 = 0; mr = 0; br = 0; req = 0; rdy = 0;
    endtask

    task automatic step(string name, int dut, resp_t r);
        item_t it;
        it.name = name; it.dut = dut; it.r = r;
        q.push_back(it);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle();
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        step("reset_state", 0, mk(1, 1, 0, 0, 0, 2'b00, 0, 0));
        rst_n = 1'b1;
        step("idle_run", 0, mk(1, 1, 0, 0, 0, 2'b00, 0, 0));

        // Single-bubble load-use
        mr = 1; rd = 5; r1 = 5; u1 = 1;
        step("lu1_bubble", 0, mk(0, 0, 0, 1, 0, 2'b00, 0, 0));
        idle();
        step("lu1_after", 0, mk(1, 1, 0, 0, 0, 2'b00, 1, 0));

        do_reset();
        mr = 1; rd = 0; r1 = 0; u1 = 1;
        step("rd_zero", 0, mk(1, 1, 0, 0, 0, 2'b00, 0, 0));
        rd = 5; r1 = 5; u1 = 0;
        step("use1_off", 0, mk(1, 1, 0, 0, 0, 2'b00, 0, 0));
        r2 = 5; u2 = 1; rd = 6;
        step("rs2_miss", 0, mk(1, 1, 0, 0, 0, 2'b00, 0, 0));

        // Two-bubble load-use on rs2
        do_reset();
        mr = 1; rd = 7; r2 = 7; u2 = 1;
        step("lu2_b1", 1, mk(0, 0, 0, 1, 0, 2'b00, 0, 0));
        idle();
        step("lu2_b2", 1, mk(0, 0, 0, 1, 0, 2'b01, 1, 0));
        step("lu2_done", 1, mk(1, 1, 0, 0, 0, 2'b00, 2, 0));

        // Branch beats a simultaneous hit
        do_reset();
        mr = 1; rd = 5; r1 = 5; u1 = 1; br = 1;
        step("br_hit", 0, mk(1, 1, 1, 1, 0, 2'b00, 0, 0));
        idle();
        step("br_after", 0, mk(1, 1, 0, 0, 0, 2'b00, 0, 1));

        // Memory wait of three cycles
        do_reset();
        req = 1;
        step("mw_c1", 0, mk(0, 0, 0, 0, 1, 2'b00, 0, 0));
        step("mw_c2", 0, mk(0, 0, 0, 0, 1, 2'b10, 1, 0));
        step("mw_c3", 0, mk(0, 0, 0, 0, 1, 2'b10, 2, 0));
        rdy = 1;
        step("mw_release", 0, mk(1, 1, 0, 0, 0, 2'b10, 3, 0));
        idle();
        step("mw_after", 0, mk(1, 1, 0, 0, 0, 2'b00, 3, 0));

        // Branch taken on the release cycle is honoured
        do_reset();
        req = 1;
        step("mwbr_wait", 0, mk(0, 0, 0, 0, 1, 2'b00, 0, 0));
        rdy = 1; br = 1;
        step("mwbr_rel", 0, mk(1, 1, 1, 1, 0, 2'b10, 1, 0));
        idle();
        step("mwbr_after", 0, mk(1, 1, 0, 0, 0, 2'b00, 1, 1));

        // Wait inside a three-bubble stall, bubble count held across it
        do_reset();
        mr = 1; rd = 9; r1 = 9; u1 = 1;
        step("ls3_hit", 2, mk(0, 0, 0, 1, 0, 2'b00, 0, 0));
        idle();
        step("ls3_b2", 2, mk(0, 0, 0, 1, 0, 2'b01, 1, 0));
        req = 1;
        step("ls3_wait1", 2, mk(0, 0, 0, 0, 1, 2'b01, 2, 0));
        step("ls3_wait2", 2, mk(0, 0, 0, 0, 1, 2'b10, 3, 0));
        rdy = 1;
        step("ls3_resume", 2, mk(0, 0, 0, 1, 0, 2'b10, 4, 0));
        idle();
        step("ls3_done", 2, mk(1, 1, 0, 0, 0, 2'b00, 5, 0));

        // Reset asserted while frozen mid-stall
        mr = 1; rd = 9; r1 = 9; u1 = 1;
        step("rs_hit", 2, mk(0, 0, 0, 1, 0, 2'b00, 5, 0));
        idle(); req = 1;
        step("rs_wait1", 2, mk(0, 0, 0, 0, 1, 2'b01, 6, 0));
        step("rs_wait2", 2, mk(0, 0, 0, 0, 1, 2'b10, 7, 0));
        rst_n = 1'b0;
        idle();
        step("rs_async", 2, mk(1, 1, 0, 0, 0, 2'b00, 0, 0));
        rst_n = 1'b1;
        step("rs_after", 2, mk(1, 1, 0, 0, 0, 2'b00, 0, 0));
        step("rs_after2", 2, mk(1, 1, 0, 0, 0, 2'b00, 0, 0));

        // Counter saturation on the 3-bit instance
        do_reset();
        req = 1;
        for (int k = 0; k < 10; k++)
            step("sat_stall", 3, mk(0, 0, 0, 0, 1, (k == 0) ? 2'b00 : 2'b10, (k > 7) ? 7 : k, 0));
        rdy = 1;
        step("sat_rel", 3, mk(1, 1, 0, 0, 0, 2'b10, 7, 0));
        idle(); br = 1;
        for (int k = 0; k < 9; k++)
            step("sat_flush", 3, mk(1, 1, 1, 1, 0, 2'b00, 7, (k > 7) ? 7 : k));
        idle();
        step("sat_final", 3, mk(1, 1, 0, 0, 0, 2'b00, 7, 7));

        for (int w = 0; w < 10 && q.size() > 0; w++) @(posedge clk);
        if (q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
